// File: rtl/tlb_params.sv
// Shared TLB types, CP0 register numbers and field helpers.
package tlb_params;

    localparam int TLB_ENTRIES = 16;
    localparam int TLB_IW = $clog2(TLB_ENTRIES);
    localparam int CACHE_W = 3;

    typedef enum logic [1:0] {
        TLBP  = 2'd0,
        TLBR  = 2'd1,
        TLBWI = 2'd2,
        TLBWR = 2'd3
    } tlb_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } cp0_state_t;

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_WIRED    = 5'd6;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

    typedef struct packed {
        logic [19:0]        pfn;
        logic [CACHE_W-1:0] c;
        logic               d;
        logic               v;
    } page_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        is_global;
        page_t       even;
        page_t       odd;
    } entry_t;

    typedef entry_t tlb_request_t;

    typedef struct packed {
        logic [18:0] vpn;
        logic [7:0]  asid;
        logic        is_odd_page;
    } search_request_t;

    typedef struct packed {
        logic              found;
        logic [TLB_IW-1:0] index;
    } search_result_t;

    typedef struct packed {
        logic [5:0]  zero;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        g;
    } entrylo_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [4:0]  zero;
        logic [7:0]  asid;
    } entryhi_t;

    function automatic entrylo_t to_entrylo(input logic [31:0] w);
        entrylo_t r;
        r      = '0;
        r.pfn  = w[25:6];
        r.c    = w[5:3];
        r.d    = w[2];
        r.v    = w[1];
        r.g    = w[0];
        return r;
    endfunction

    function automatic page_t to_page(input entrylo_t lo);
        page_t p;
        p.pfn = lo.pfn;
        p.c   = lo.c[CACHE_W-1:0];
        p.d   = lo.d;
        p.v   = lo.v;
        return p;
    endfunction

    function automatic entrylo_t from_page(input page_t p, input logic g);
        entrylo_t r;
        r     = '0;
        r.pfn = p.pfn;
        r.c   = 3'(p.c);
        r.d   = p.d;
        r.v   = p.v;
        r.g   = g;
        return r;
    endfunction

endpackage

// File: rtl/tlb_random_counter.sv
// CP0 Random: free-running down counter that wraps above Wired.
module tlb_random_counter
    import tlb_params::*;
#(
    parameter int TLB_NUM = TLB_ENTRIES,
    localparam int IW = $clog2(TLB_NUM)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [IW-1:0] wired,
    input  logic          wired_write,
    output logic [IW-1:0] random
);

    localparam logic [IW-1:0] TOP = IW'(TLB_NUM - 1);

    // Reaching Wired (or Wired at TOP) reloads, so wired slots are never picked.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            random <= TOP;
        end else if (wired_write || random <= wired) begin
            random <= TOP;
        end else begin
            random <= random - 1'b1;
        end
    end

endmodule

// File: rtl/tlb_cp0_unit.sv
// TLB-management CP0 registers and TLBP/TLBR/TLBWI/TLBWR sequencing.
module tlb_cp0_unit
    import tlb_params::*;
#(
    parameter int TLB_NUM = TLB_ENTRIES,
    localparam int IW = $clog2(TLB_NUM)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            op_valid,
    input  tlb_op_t         op_type,
    output logic            op_ready,
    output logic            op_done,
    input  logic            cp0_write_enable,
    input  logic [4:0]      cp0_write_addr,
    input  logic [31:0]     cp0_write_data,
    input  logic [4:0]      cp0_read_addr,
    output logic [31:0]     cp0_read_data,
    output logic [7:0]      current_asid,
    output search_request_t tlb_search_request,
    input  search_result_t  tlb_search_result,
    output logic            tlb_write_enabled,
    output logic [IW-1:0]   tlb_write_index,
    output tlb_request_t    tlb_write_data,
    output logic [IW-1:0]   tlb_read_index,
    input  tlb_request_t    tlb_read_data
);

    cp0_state_t    state;
    tlb_op_t       op_q;
    logic [IW-1:0] idx_q;

    logic          index_p;
    logic [IW-1:0] index_idx;
    logic [IW-1:0] wired;
    logic [IW-1:0] random;
    entrylo_t      entrylo0;
    entrylo_t      entrylo1;
    entryhi_t      entryhi;

    logic wired_write;
    logic probe_done;
    logic read_done;
    logic unused_bits;

    assign wired_write = cp0_write_enable && cp0_write_addr == CP0_WIRED;
    assign probe_done  = state == EXEC && op_q == TLBP;
    assign read_done   = state == EXEC && op_q == TLBR;
    assign unused_bits = ^cp0_write_data[12:8];

    tlb_random_counter #(.TLB_NUM(TLB_NUM)) u_random (
        .clock       (clock),
        .reset_n     (reset_n),
        .wired       (wired),
        .wired_write (wired_write),
        .random      (random)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_ready <= 1'b1;
            op_done  <= 1'b0;
            op_q     <= TLBP;
            idx_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    op_done <= 1'b0;
                    if (op_valid) begin
                        op_q     <= op_type;
                        idx_q    <= (op_type == TLBWR) ? random : index_idx;
                        state    <= EXEC;
                        op_ready <= 1'b0;
                        op_done  <= 1'b1;
                    end
                end
                EXEC: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                    op_done  <= 1'b0;
                end
            endcase
        end
    end

    // Op results are assigned last so they win over a same-cycle mtc0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index_p   <= 1'b0;
            index_idx <= '0;
            wired     <= '0;
            entrylo0  <= '0;
            entrylo1  <= '0;
            entryhi   <= '0;
        end else begin
            if (cp0_write_enable) begin
                case (cp0_write_addr)
                    CP0_INDEX: begin
                        index_p   <= cp0_write_data[31];
                        index_idx <= cp0_write_data[IW-1:0];
                    end
                    CP0_ENTRYLO0: entrylo0 <= to_entrylo(cp0_write_data);
                    CP0_ENTRYLO1: entrylo1 <= to_entrylo(cp0_write_data);
                    CP0_WIRED:    wired    <= cp0_write_data[IW-1:0];
                    CP0_ENTRYHI: begin
                        entryhi.vpn2 <= cp0_write_data[31:13];
                        entryhi.zero <= '0;
                        entryhi.asid <= cp0_write_data[7:0];
                    end
                    default: ;
                endcase
            end
            if (probe_done) begin
                index_p   <= !tlb_search_result.found;
                index_idx <= tlb_search_result.found ?
                             IW'(tlb_search_result.index) : index_idx;
            end
            if (read_done) begin
                entryhi.vpn2 <= tlb_read_data.vpn2;
                entryhi.zero <= '0;
                entryhi.asid <= tlb_read_data.asid;
                entrylo0 <= from_page(tlb_read_data.even, tlb_read_data.is_global);
                entrylo1 <= from_page(tlb_read_data.odd, tlb_read_data.is_global);
            end
        end
    end

    always_comb begin
        cp0_read_data = '0;
        case (cp0_read_addr)
            CP0_INDEX: begin
                cp0_read_data[31]     = index_p;
                cp0_read_data[IW-1:0] = index_idx;
            end
            CP0_RANDOM:   cp0_read_data[IW-1:0] = random;
            CP0_ENTRYLO0: cp0_read_data = entrylo0;
            CP0_ENTRYLO1: cp0_read_data = entrylo1;
            CP0_WIRED:    cp0_read_data[IW-1:0] = wired;
            CP0_ENTRYHI:  cp0_read_data = entryhi;
            default:      cp0_read_data = '0;
        endcase
    end

    assign current_asid = entryhi.asid;

    assign tlb_search_request.vpn         = entryhi.vpn2;
    assign tlb_search_request.asid        = entryhi.asid;
    assign tlb_search_request.is_odd_page = 1'b0;

    assign tlb_read_index    = index_idx;
    assign tlb_write_enabled = state == EXEC && (op_q == TLBWI || op_q == TLBWR);
    assign tlb_write_index   = idx_q;

    assign tlb_write_data.vpn2      = entryhi.vpn2;
    assign tlb_write_data.asid      = entryhi.asid;
    assign tlb_write_data.is_global = entrylo0.g & entrylo1.g;
    assign tlb_write_data.even      = to_page(entrylo0);
    assign tlb_write_data.odd       = to_page(entrylo1);

endmodule

// File: tb/tb_tlb_cp0_unit.sv
// Directed plus randomized checks of tlb_cp0_unit against a behavioural TLB model.
module tb_tlb_cp0_unit;
    import tlb_params::*;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            op_valid = 1'b0;
    tlb_op_t         op_type = TLBP;
    logic            op_ready;
    logic            op_done;
    logic            cp0_write_enable = 1'b0;
    logic [4:0]      cp0_write_addr = '0;
    logic [31:0]     cp0_write_data = '0;
    logic [4:0]      cp0_read_addr = '0;
    logic [31:0]     cp0_read_data;
    logic [7:0]      current_asid;
    search_request_t sreq;
    search_result_t  sres;
    logic            tlb_write_enabled;
    logic [3:0]      tlb_write_index;
    tlb_request_t    tlb_write_data;
    logic [3:0]      tlb_read_index;
    tlb_request_t    tlb_read_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    entry_t mem [16];

    always #5 clock = ~clock;

    tlb_cp0_unit #(.TLB_NUM(16)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .op_valid           (op_valid),
        .op_type            (op_type),
        .op_ready           (op_ready),
        .op_done            (op_done),
        .cp0_write_enable   (cp0_write_enable),
        .cp0_write_addr     (cp0_write_addr),
        .cp0_write_data     (cp0_write_data),
        .cp0_read_addr      (cp0_read_addr),
        .cp0_read_data      (cp0_read_data),
        .current_asid       (current_asid),
        .tlb_search_request (sreq),
        .tlb_search_result  (sres),
        .tlb_write_enabled  (tlb_write_enabled),
        .tlb_write_index    (tlb_write_index),
        .tlb_write_data     (tlb_write_data),
        .tlb_read_index     (tlb_read_index),
        .tlb_read_data      (tlb_read_data)
    );

    // Behavioural TLB array: lowest matching index wins.
    always @(posedge clock) begin
        if (tlb_write_enabled) begin
            mem[tlb_write_index] <= tlb_write_data;
            wr_cnt++;
        end
        if (op_done) done_cnt++;
    end

    always_comb begin
        sres = '0;
        for (int i = 0; i < 16; i++) begin
            if (!sres.found && mem[i].vpn2 == sreq.vpn &&
                (mem[i].is_global || mem[i].asid == sreq.asid)) begin
                sres.found = 1'b1;
                sres.index = 4'(i);
            end
        end
    end

    assign tlb_read_data = mem[tlb_read_index];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_write_enable = 1'b1;
        cp0_write_addr   = a;
        cp0_write_data   = d;
        tick;
        cp0_write_enable = 1'b0;
    endtask

    task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
        cp0_read_addr = a;
        #1;
        d = cp0_read_data;
    endtask

    task automatic run_op(input tlb_op_t op, output logic we,
                          output logic [3:0] wi, output entry_t wd);
        int n = 0;
        while (op_ready !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        chk("ready_wait", op_ready, 1'b1);
        op_valid = 1'b1;
        op_type  = op;
        tick;
        op_valid = 1'b0;
        chk("done_in_exec", op_done, 1'b1);
        chk("busy_in_exec", op_ready, 1'b0);
        we = tlb_write_enabled;
        wi = tlb_write_index;
        wd = tlb_write_data;
        tick;
        chk("done_after", op_done, 1'b0);
        chk("strobe_after", tlb_write_enabled, 1'b0);
    endtask

    function automatic entry_t exp_entry(input logic [31:0] eh,
                                         input logic [31:0] lo0,
                                         input logic [31:0] lo1);
        entry_t e;
        e.vpn2      = eh[31:13];
        e.asid      = eh[7:0];
        e.is_global = lo0[0] & lo1[0];
        e.even.pfn  = lo0[25:6];
        e.even.c    = lo0[5:3];
        e.even.d    = lo0[2];
        e.even.v    = lo0[1];
        e.odd.pfn   = lo1[25:6];
        e.odd.c     = lo1[5:3];
        e.odd.d     = lo1[2];
        e.odd.v     = lo1[1];
        return e;
    endfunction

    function automatic logic [31:0] lo_after_read(input logic [31:0] lo,
                                                  input logic g);
        return (lo & 32'h03FF_FFFE) | {31'd0, g};
    endfunction

    function automatic logic [31:0] reg_view(input logic [4:0] a,
                                             input logic [31:0] d);
        logic [31:0] m;
        case (a)
            5'd0:       m = 32'h8000_000F;
            5'd2, 5'd3: m = 32'h03FF_FFFF;
            5'd6:       m = 32'h0000_000F;
            5'd10:      m = 32'hFFFF_E0FF;
            default:    m = 32'h0;
        endcase
        return d & m;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rnd;
        logic [31:0] eh, lo0, lo1;
        logic [3:0]  idx;
        logic        we;
        logic [3:0]  wi;
        entry_t      wd;
        int          w0, d0;
        logic [4:0]  addrs [8];

        addrs = '{5'd0, 5'd2, 5'd3, 5'd6, 5'd10, 5'd4, 5'd5, 5'd31};
        for (int i = 0; i < 16; i++) mem[i] = '0;

        #12 reset_n = 1'b1;
        mfc0(5'd1, rd);  chk("reset_random", rd, 32'd15);
        mfc0(5'd0, rd);  chk("reset_index", rd, 32'd0);
        mfc0(5'd10, rd); chk("reset_entryhi", rd, 32'd0);
        chk("reset_ready", op_ready, 1'b1);
        chk("reset_done", op_done, 1'b0);
        chk("reset_strobe", tlb_write_enabled, 1'b0);
        tick;

        mtc0(5'd6, 32'd4);
        mfc0(5'd6, rd); chk("wired", rd, 32'd4);
        exp_rnd = 15;
        for (int k = 0; k < 14; k++) begin
            mfc0(5'd1, rd);
            chk("random_seq", rd, exp_rnd);
            exp_rnd = (exp_rnd <= 4) ? 32'd15 : exp_rnd - 1;
            tick;
        end

        eh = 32'h0000_2005; lo0 = 32'h0000_005F; lo1 = 32'h0000_0097;
        mtc0(5'd10, eh); mtc0(5'd2, lo0); mtc0(5'd3, lo1); mtc0(5'd0, 32'd3);
        chk("asid_out", current_asid, 8'd5);
        w0 = wr_cnt;
        run_op(TLBWI, we, wi, wd);
        chk("wi_strobe", we, 1'b1);
        chk("wi_index", wi, 4'd3);
        chk("wi_data", wd, exp_entry(eh, lo0, lo1));
        chk("wi_vpn2", wd.vpn2, 19'd1);
        chk("wi_global", wd.is_global, 1'b1);
        chk("wi_one_write", wr_cnt - w0, 1);

        mtc0(5'd10, 32'h0000_2009);
        chk("probe_req", sreq, {19'd1, 8'd9, 1'b0});
        run_op(TLBP, we, wi, wd);
        chk("tlbp_no_write", we, 1'b0);
        mfc0(5'd0, rd); chk("tlbp_hit", rd, 32'h0000_0003);

        lo0 = 32'h0000_005E;
        mtc0(5'd10, eh); mtc0(5'd2, lo0);
        run_op(TLBWI, we, wi, wd);
        chk("rewrite_global", wd.is_global, 1'b0);
        mtc0(5'd10, 32'h0000_2009);
        run_op(TLBP, we, wi, wd);
        mfc0(5'd0, rd); chk("tlbp_miss", rd, 32'h8000_0003);

        mtc0(5'd0, 32'd3);
        mtc0(5'd10, 32'hFFFF_FFFF);
        mtc0(5'd2, $urandom); mtc0(5'd3, $urandom);
        run_op(TLBR, we, wi, wd);
        mfc0(5'd10, rd); chk("tlbr_hi", rd, eh);
        mfc0(5'd2, rd);  chk("tlbr_lo0", rd, lo_after_read(lo0, lo0[0] & lo1[0]));
        mfc0(5'd3, rd);  chk("tlbr_lo1", rd, lo_after_read(lo1, lo0[0] & lo1[0]));

        mfc0(5'd1, rd);
        op_valid = 1'b1; op_type = TLBWR;
        tick;
        op_valid = 1'b0;
        chk("wr_strobe", tlb_write_enabled, 1'b1);
        chk("wr_index", tlb_write_index, rd[3:0]);
        chk("wr_range", (rd >= 4 && rd <= 15), 1'b1);
        tick;

        mtc0(5'd0, 32'd7); mtc0(5'd10, eh);
        op_valid = 1'b1; op_type = TLBP;
        tick;
        op_valid = 1'b0;
        mtc0(5'd0, 32'h0000_000A);
        mfc0(5'd0, rd); chk("collision_index", rd, 32'd3);

        d0 = done_cnt;
        op_valid = 1'b1; op_type = TLBP;
        tick; chk("held_busy", op_ready, 1'b0);
        tick; tick;
        op_valid = 1'b0;
        tick;
        chk("held_two_ops", done_cnt - d0, 2);

        repeat (6) begin
            eh = $urandom; lo0 = $urandom; lo1 = $urandom;
            idx = 4'($urandom_range(0, 15));
            mtc0(5'd10, eh); mtc0(5'd2, lo0); mtc0(5'd3, lo1);
            mtc0(5'd0, {28'd0, idx});
            run_op(TLBWI, we, wi, wd);
            chk("rnd_wi_index", wi, idx);
            chk("rnd_wi_data", wd, exp_entry(eh, lo0, lo1));
            mtc0(5'd10, ~eh); mtc0(5'd2, ~lo0); mtc0(5'd3, ~lo1);
            run_op(TLBR, we, wi, wd);
            mfc0(5'd10, rd); chk("rnd_tlbr_hi", rd, eh & 32'hFFFF_E0FF);
            mfc0(5'd2, rd);
            chk("rnd_tlbr_lo0", rd, lo_after_read(lo0, lo0[0] & lo1[0]));
            mfc0(5'd3, rd);
            chk("rnd_tlbr_lo1", rd, lo_after_read(lo1, lo0[0] & lo1[0]));
        end

        repeat (12) begin
            logic [4:0] a;
            logic [31:0] d;
            a = addrs[$urandom_range(0, 7)];
            d = $urandom;
            mtc0(a, d);
            mfc0(a, rd);
            chk("rnd_reg", rd, reg_view(a, d));
        end

        mtc0(5'd0, 32'd5);
        mtc0(5'd10, 32'h1234_5678);
        w0 = wr_cnt;
        d0 = done_cnt;
        op_valid = 1'b1; op_type = TLBWI;
        tick;
        op_valid = 1'b0;
        chk("rst_pre_strobe", tlb_write_enabled, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_strobe_low", tlb_write_enabled, 1'b0);
        tick; tick;
        chk("rst_no_write", wr_cnt - w0, 0);
        chk("rst_no_done", done_cnt - d0, 0);
        mfc0(5'd0, rd);  chk("rst_index", rd, 32'd0);
        mfc0(5'd10, rd); chk("rst_entryhi", rd, 32'd0);
        mfc0(5'd2, rd);  chk("rst_lo0", rd, 32'd0);
        mfc0(5'd3, rd);  chk("rst_lo1", rd, 32'd0);
        mfc0(5'd6, rd);  chk("rst_wired", rd, 32'd0);
        mfc0(5'd1, rd);  chk("rst_random", rd, 32'd15);
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_done", op_done, 1'b0);
        reset_n = 1'b1;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
